btn_input: RTL and testbench

BTN_INPUT -- requirements
Module: btn_input

---
 rtl/btn_input_pkg.sv | 24 ++
 rtl/btn_input_debounce.sv | 46 ++++
 rtl/btn_input.sv | 145 ++++++++++++++
 tb/tb_btn_input.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/btn_input_pkg.sv
// btn_input_pkg -- shared constants for the button/switch front end.
//   NUM_BTN / SW_W     : number of push buttons and switch width
//   *_DEF              : default timing parameters (in mclk cycles)
//   cnt_width()        : counter width sized from the largest timing parameter
package btn_input_pkg;

  localparam int NUM_BTN       = 4;
  localparam int SW_W          = 8;

  localparam int DEBOUNCE_DEF  = 500000;
  localparam int REP_DELAY_DEF = 25000000;
  localparam int REP_RATE_DEF  = 5000000;

  // Counters only ever hold (param - 1), so clog2 of the largest parameter
  // is enough; keep at least one bit for degenerate parameter values.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/btn_input_debounce.sv
// debounce -- per-button debouncer.
//   mclk, rst : clock, asynchronous active-high reset
//   din       : synchronized raw button level
//   level     : debounced level (registered)
//   rise      : one-cycle pulse, high in the first cycle level reads 1
// The level flips only after din has disagreed with it for DEBOUNCE
// consecutive cycles; a single agreeing sample restarts the count.
module debounce
  import btn_input_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEF,
  parameter int CW       = 1
) (
  input  logic mclk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      cnt   <= '0;
    end else begin
      rise <= 1'b0;
      if (din == level) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        // DEBOUNCE-th disagreeing sample: accept the new level. The >=
        // compare also keeps the counter from ever wrapping.
        level <= din;
        rise  <= din;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_input.sv
// btn_input -- debounced button/switch command source.
//   mclk, rst   : clock, asynchronous active-high reset
//   sw, btn     : raw asynchronous switches / active-high buttons
//   out_valid   : command present (registered)
//   out_btn     : mask of buttons that produced this command
//   out_sw      : synchronized switch value captured with the command
//   in_ready    : consumer accepts the command this cycle
//   out_dropped : one-cycle pulse when an event found the buffer full
// Press events (debounced 0->1) from the same cycle merge into one mask.
// A lone held button auto-repeats after REP_DELAY, then every REP_RATE.
module btn_input
  import btn_input_pkg::*;
#(
  parameter int DEBOUNCE  = DEBOUNCE_DEF,
  parameter int REP_DELAY = REP_DELAY_DEF,
  parameter int REP_RATE  = REP_RATE_DEF
) (
  input  logic               mclk,
  input  logic               rst,
  input  logic [SW_W-1:0]    sw,
  input  logic [NUM_BTN-1:0] btn,
  output logic               out_valid,
  output logic [NUM_BTN-1:0] out_btn,
  output logic [SW_W-1:0]    out_sw,
  input  logic               in_ready,
  output logic               out_dropped
);

  localparam int CW = cnt_width(DEBOUNCE, REP_DELAY, REP_RATE);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REP_DELAY - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REP_RATE - 1);

  // ---------------------------------------------------------------
  // Two-flop synchronizers; nothing downstream sees raw inputs.
  // ---------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_m, btn_s;
  logic [SW_W-1:0]    sw_m, sw_s;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      btn_m <= '0;
      btn_s <= '0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      sw_m  <= sw;
      sw_s  <= sw_m;
    end
  end

  // ---------------------------------------------------------------
  // Per-button debounce
  // ---------------------------------------------------------------
  logic [NUM_BTN-1:0] lvl, rise;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
    debounce #(
      .DEBOUNCE (DEBOUNCE),
      .CW       (CW)
    ) u_db (
      .mclk  (mclk),
      .rst   (rst),
      .din   (btn_s[g]),
      .level (lvl[g]),
      .rise  (rise[g])
    );
  end

  // ---------------------------------------------------------------
  // Auto-repeat. Armed only by a press that leaves exactly one button
  // down; any other level change disarms and clears the timer. rep_cnt
  // holds (cycles since last event - 1) so it never needs to reach the
  // parameter value itself.
  // ---------------------------------------------------------------
  logic          single;
  logic          rep_armed;
  logic          rep_phase;   // 0: waiting REP_DELAY, 1: REP_RATE cadence
  logic [CW-1:0] rep_cnt;
  logic [CW-1:0] rep_target;
  logic          rep_fire;

  assign single     = $onehot(lvl);
  assign rep_target = rep_phase ? RATE_LAST : DELAY_LAST;
  assign rep_fire   = rep_armed && single && (rise == '0) && (rep_cnt == rep_target);

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      rep_armed <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (!single) begin
      rep_armed <= 1'b0;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (rise != '0) begin
      // single && rise: the only button down was just pressed
      rep_armed <= 1'b1;
      rep_phase <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_armed) begin
      if (rep_fire) begin
        rep_phase <= 1'b1;
        rep_cnt   <= '0;
      end else if (rep_cnt != '1) begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------
  // Event merge and one-entry output buffer
  // ---------------------------------------------------------------
  logic [NUM_BTN-1:0] ev_mask;
  logic               ev;

  assign ev_mask = rise | (rep_fire ? lvl : '0);
  assign ev      = |ev_mask;

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_btn     <= '0;
      out_sw      <= '0;
      out_dropped <= 1'b0;
    end else begin
      out_dropped <= 1'b0;
      if (ev) begin
        if (!out_valid || in_ready) begin
          // empty, or the held command leaves this edge: load with no bubble
          out_valid <= 1'b1;
          out_btn   <= ev_mask;
          out_sw    <= sw_s;
        end else begin
          // buffer full and stalled: keep the old command
          out_dropped <= 1'b1;
        end
      end else if (in_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_input.sv
module tb_btn_input;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic       mclk = 1'b0;
  logic       rst  = 1'b1;
  logic [7:0] sw   = '0;
  logic [3:0] btn  = '0;
  logic       in_ready = 1'b1;
  logic       out_valid, out_dropped;
  logic [3:0] out_btn;
  logic [7:0] out_sw;

  int checks = 0;
  int errors = 0;

  btn_input #(.DEBOUNCE(DB), .REP_DELAY(RD), .REP_RATE(RR)) dut (
    .mclk        (mclk),
    .rst         (rst),
    .sw          (sw),
    .btn         (btn),
    .out_valid   (out_valid),
    .out_btn     (out_btn),
    .out_sw      (out_sw),
    .in_ready    (in_ready),
    .out_dropped (out_dropped)
  );

  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] b;
    logic [7:0] s;
    int         hold;
    int         exp_n;
    int         exp_lat;
    logic [3:0] exp_btn;
    logic [7:0] exp_sw;
  } vec_t;

  vec_t tbl[5];
  int   rep_exp[5];

  initial begin
    int n, first, drops, stable, found;
    logic [3:0] m;
    logic [7:0] sv;
    int times[8];

    // hold counts cycles btn is driven; latency = steps until out_valid
    tbl[0] = '{4'b0001, 8'h3C, 10, 1, 7, 4'b0001, 8'h3C};
    tbl[1] = '{4'b1010, 8'hA5, 10, 1, 7, 4'b1010, 8'hA5};
    tbl[2] = '{4'b0100, 8'h11,  3, 0, 0, 4'b0000, 8'h00};  // one short of DEBOUNCE
    tbl[3] = '{4'b1000, 8'hFF,  4, 1, 7, 4'b1000, 8'hFF};  // exactly DEBOUNCE
    tbl[4] = '{4'b0000, 8'h55, 10, 0, 0, 4'b0000, 8'h00};
    rep_exp = '{7, 27, 35, 43, 51};

    // reset state
    step(); step();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_btn", out_btn, 0);
    chk("reset out_sw", out_sw, 0);
    chk("reset out_dropped", out_dropped, 0);
    rst = 1'b0;
    repeat (4) step();

    // table-driven single presses, in_ready=1
    for (int i = 0; i < 5; i++) begin
      btn = tbl[i].b; sw = tbl[i].s;
      n = 0; first = -1; m = '0; sv = '0; drops = 0;
      for (int c = 1; c <= tbl[i].hold + 14; c++) begin
        step();
        if (out_dropped) drops++;
        if (out_valid) begin
          n++;
          if (first < 0) begin first = c; m = out_btn; sv = out_sw; end
        end
        if (c == tbl[i].hold) btn = '0;
      end
      chk($sformatf("vec%0d count", i), n, tbl[i].exp_n);
      chk($sformatf("vec%0d dropped", i), drops, 0);
      if (tbl[i].exp_n > 0) begin
        chk($sformatf("vec%0d latency", i), first, tbl[i].exp_lat);
        chk($sformatf("vec%0d out_btn", i), m, tbl[i].exp_btn);
        chk($sformatf("vec%0d out_sw", i), sv, tbl[i].exp_sw);
      end
    end

    // bounce: btn[1] toggles every 2 cycles for 20 cycles then low
    n = 0;
    for (int c = 0; c < 20; c++) begin
      btn = {2'b00, ((c / 2) % 2 == 0), 1'b0};
      step();
      if (out_valid) n++;
    end
    btn = '0;
    repeat (14) begin step(); if (out_valid) n++; end
    chk("bounce events", n, 0);

    // auto-repeat: btn[2] held 50 cycles
    btn = 4'b0100; sw = 8'h5A; n = 0; stable = 1;
    for (int c = 1; c <= 75; c++) begin
      step();
      if (out_valid) begin
        if (n < 8) times[n] = c;
        if (out_btn != 4'b0100) stable = 0;
        n++;
      end
      if (c == 50) btn = '0;
    end
    chk("repeat count", n, 5);
    chk("repeat mask", stable, 1);
    for (int k = 0; k < 5; k++)
      if (k < n) chk($sformatf("repeat t%0d", k), times[k], rep_exp[k]);
    repeat (4) step();

    // backpressure: first command held stable, second dropped once
    in_ready = 1'b0; sw = 8'h11; btn = 4'b0001; stable = 1; drops = 0;
    for (int c = 1; c <= 34; c++) begin
      step();
      if (out_dropped) drops++;
      if (c >= 7 && (!out_valid || out_btn != 4'b0001 || out_sw != 8'h11)) stable = 0;
      if (c == 10) btn = '0;
      if (c == 12) sw = 8'h22;
      if (c == 14) btn = 4'b1000;
      if (c == 24) btn = '0;
    end
    chk("bp held stable", stable, 1);
    chk("bp dropped pulses", drops, 1);
    chk("bp valid before ready", out_valid, 1);
    in_ready = 1'b1;
    step();
    chk("bp transferred", out_valid, 0);
    chk("bp no drop on transfer", out_dropped, 0);
    repeat (6) step();

    // reset mid-handshake, button held through reset release
    in_ready = 1'b0; btn = 4'b0010; sw = 8'h77; found = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      step();
      if (out_valid) found = 1;
    end
    chk("rst pre valid", found, 1);
    rst = 1'b1;
    #1;
    chk("rst clears valid", out_valid, 0);
    chk("rst no dropped", out_dropped, 0);
    chk("rst clears out_btn", out_btn, 0);
    step(); step();
    rst = 1'b0;
    first = -1; drops = 0;
    for (int c = 1; c <= 20 && first < 0; c++) begin
      step();
      if (out_dropped) drops++;
      if (out_valid) first = c;
    end
    chk("post-rst latency", first, 7);
    chk("post-rst mask", out_btn, 4'b0010);
    chk("post-rst sw", out_sw, 8'h77);
    chk("post-rst dropped", drops, 0);
    in_ready = 1'b1; btn = '0;
    repeat (12) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
